// File: rtl/ar_issue_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ar_arb_pkg
//  Brief   : AR FIFO word layout, arbiter state encoding and packing helper.
//  Rev     : 1.0  initial release
// ============================================================================
package ar_arb_pkg;

  localparam int BURST_LSB = 0;
  localparam int SIZE_LSB  = 2;
  localparam int LEN_LSB   = 5;
  localparam int ADDR_LSB  = 9;
  localparam int ID_LSB    = 41;
  localparam int AR_WORD_W = 49;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_word_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PUSH = 1'b1
  } arb_state_t;

  // The master index becomes the upper ID nibble so R responses can be routed back.
  function automatic ar_word_t pack_ar(input logic [3:0]  mst,
                                       input logic [3:0]  id,
                                       input logic [31:0] addr,
                                       input logic [3:0]  len,
                                       input logic [2:0]  size,
                                       input logic [1:0]  burst);
    ar_word_t w;
    w.id    = {mst, id};
    w.addr  = addr;
    w.len   = len;
    w.size  = size;
    w.burst = burst;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ar_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module  : ar_issue_arbiter_if
//  Brief   : Per-master AR request bundle, FIFO write side and retire path.
//  Rev     : 1.0  initial release
// ============================================================================
interface ar_issue_arbiter_if #(
  parameter int NUM_MST = 3
);
  import ar_arb_pkg::*;

  logic [NUM_MST-1:0]       arvalid_m;
  logic [NUM_MST-1:0]       arready_m;
  logic [NUM_MST-1:0][3:0]  arid_m;
  logic [NUM_MST-1:0][31:0] araddr_m;
  logic [NUM_MST-1:0][3:0]  arlen_m;
  logic [NUM_MST-1:0][2:0]  arsize_m;
  logic [NUM_MST-1:0][1:0]  arburst_m;
  logic                     wpush;
  logic [AR_WORD_W-1:0]     wdata;
  logic                     wfull;
  logic                     rdone;
  logic [3:0]               rdone_mst;
  logic [NUM_MST-1:0][3:0]  outs_cnt;

  // Arbiter side
  modport slave (
    input  arvalid_m, arid_m, araddr_m, arlen_m, arsize_m, arburst_m,
    input  wfull, rdone, rdone_mst,
    output arready_m, wpush, wdata, outs_cnt
  );

  // Masters / FIFO / R-path side
  modport master (
    output arvalid_m, arid_m, araddr_m, arlen_m, arsize_m, arburst_m,
    output wfull, rdone, rdone_mst,
    input  arready_m, wpush, wdata, outs_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ar_issue_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker, searching upward from last_grant+1.
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_MST = 3
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [3:0]         last_grant,
  output logic [NUM_MST-1:0] grant,
  output logic [3:0]         winner
);

  logic       w_hi_hit;
  logic [3:0] w_hi_idx;
  logic       w_lo_hit;
  logic [3:0] w_lo_idx;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hi_hit = 1'b0;
    w_hi_idx = 4'd0;
    w_lo_hit = 1'b0;
    w_lo_idx = 4'd0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (req[i] && (4'(i) > last_grant)) begin
        w_hi_hit = 1'b1;
        w_hi_idx = 4'(i);
      end
      if (req[i]) begin
        w_lo_hit = 1'b1;
        w_lo_idx = 4'(i);
      end
    end
  end

  always_comb begin
    winner = w_hi_hit ? w_hi_idx : w_lo_idx;
    grant  = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      grant[i] = w_lo_hit && (winner == 4'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/ar_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : ar_issue_arbiter
//  Brief   : Round-robin AR issue arbiter in front of the read-address CDC FIFO,
//            with per-master outstanding-read limiting.
//  Rev     : 1.0  initial release
// ============================================================================
module ar_issue_arbiter
  import ar_arb_pkg::*;
#(
  parameter int NUM_MST  = 3,
  parameter int MAX_OUTS = 4
) (
  input  logic              clk,
  input  logic              rstn,
  ar_issue_arbiter_if.slave bus
);

  arb_state_t               r_state;
  arb_state_t               w_state_nxt;
  ar_word_t                 r_hold;
  logic [3:0]               r_winner;
  logic [3:0]               r_last_grant;
  logic [NUM_MST-1:0][3:0]  r_outs;

  logic [NUM_MST-1:0]       w_elig;
  logic [NUM_MST-1:0]       w_grant;
  logic [3:0]               w_pick;
  logic                     w_any;
  logic                     w_hs;
  logic                     w_accept;
  ar_word_t                 w_word;

  generate
    for (genvar i = 0; i < NUM_MST; i++) begin : g_elig
      assign w_elig[i] = bus.arvalid_m[i] && (r_outs[i] < 4'(MAX_OUTS));
    end
  endgenerate

  rr_pick #(.NUM_MST(NUM_MST)) u_pick (
    .req        (w_elig),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .winner     (w_pick)
  );

  assign w_any    = |w_grant;
  assign w_hs     = (r_state == ARB_IDLE) && w_any;
  assign w_accept = (r_state == ARB_PUSH) && !bus.wfull;

  // One-hot grant steers the winning master's fields into the FIFO word.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (w_grant[i]) begin
        w_word = pack_ar(4'(i), bus.arid_m[i], bus.araddr_m[i], bus.arlen_m[i],
                         bus.arsize_m[i], bus.arburst_m[i]);
      end
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_any)      w_state_nxt = ARB_PUSH;
      ARB_PUSH: if (!bus.wfull) w_state_nxt = ARB_IDLE;
      default:                  w_state_nxt = ARB_IDLE;
    endcase
  end

  // ARREADY is gated by rstn so no handshake is signalled while held in reset.
  always_comb begin
    bus.arready_m = ((r_state == ARB_IDLE) && rstn) ? w_grant : '0;
    bus.wpush     = (r_state == ARB_PUSH);
    bus.wdata     = r_hold;
  end

  // ------------------------------------------------- hold / grant tracking --
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold       <= '0;
      r_winner     <= 4'd0;
      r_last_grant <= 4'(NUM_MST - 1);
    end else begin
      if (w_hs) begin
        r_hold   <= w_word;
        r_winner <= w_pick;
      end
      if (w_accept) r_last_grant <= r_winner;
    end
  end

  // ------------------------------------------------ outstanding counters ----
  generate
    for (genvar i = 0; i < NUM_MST; i++) begin : g_cnt
      logic w_inc;
      logic w_dec;

      assign w_inc = w_accept && (r_winner == 4'(i));
      assign w_dec = bus.rdone && (bus.rdone_mst == 4'(i)) && (r_outs[i] != 4'd0);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)              r_outs[i] <= 4'd0;
        else if (w_inc && !w_dec) r_outs[i] <= r_outs[i] + 4'd1;
        else if (w_dec && !w_inc) r_outs[i] <= r_outs[i] - 4'd1;
      end
    end
  endgenerate

  assign bus.outs_cnt = r_outs;

endmodule
`default_nettype wire

// File: tb/tb_ar_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ar_issue_arbiter
//  Brief   : Directed, table-driven bench for the AR issue arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ar_issue_arbiter;
  import ar_arb_pkg::*;

  localparam int NM = 3;
  localparam int NV = 33;

  typedef struct {
    logic [2:0]  vld;
    logic        full;
    logic        rd;
    logic [3:0]  rdm;
    logic [2:0]  rdy;
    logic        push;
    int          pm;
    logic [11:0] cnt;   // {cnt2, cnt1, cnt0}
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ar_issue_arbiter_if #(.NUM_MST(NM)) bus_if ();

  ar_issue_arbiter #(.NUM_MST(NM), .MAX_OUTS(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int acc_before;
  vec_t vt [NV];
  logic [48:0] wexp [NM];

  always @(posedge clk) begin
    if (rstn && bus_if.wpush && !bus_if.wfull) accepts <= accepts + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] vld, input logic full, input logic rd, input logic [3:0] rdm);
    bus_if.arvalid_m = vld;
    bus_if.wfull     = full;
    bus_if.rdone     = rd;
    bus_if.rdone_mst = rdm;
  endtask

  initial begin
    wexp[0] = {8'h0A, 32'h0000_1234, 4'd0, 3'd1, 2'b00};
    wexp[1] = {8'h13, 32'h1000_0040, 4'd3, 3'd2, 2'b01};
    wexp[2] = {8'h25, 32'hDEAD_BEE0, 4'hF, 3'd3, 2'b10};

    //          vld    full  rd    rdm   rdy    push  pm  cnt
    vt[0]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b001, 1'b0, -1, 12'h000};
    vt[1]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h000};
    vt[2]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b010, 1'b0, -1, 12'h001};
    vt[3]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  1, 12'h001};
    vt[4]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b100, 1'b0, -1, 12'h011};
    vt[5]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  2, 12'h011};
    vt[6]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b001, 1'b0, -1, 12'h111};
    vt[7]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h111};
    vt[8]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b010, 1'b0, -1, 12'h112};
    vt[9]  = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  1, 12'h112};
    vt[10] = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b100, 1'b0, -1, 12'h122};
    vt[11] = '{3'b111, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  2, 12'h122};
    vt[12] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b001, 1'b0, -1, 12'h222};
    vt[13] = '{3'b001, 1'b1, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[14] = '{3'b001, 1'b1, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[15] = '{3'b001, 1'b1, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[16] = '{3'b001, 1'b1, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[17] = '{3'b001, 1'b1, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[18] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h222};
    vt[19] = '{3'b000, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0, -1, 12'h223};
    vt[20] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b001, 1'b0, -1, 12'h223};
    vt[21] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h223};
    vt[22] = '{3'b101, 1'b0, 1'b0, 4'd0, 3'b100, 1'b0, -1, 12'h224};
    vt[23] = '{3'b101, 1'b0, 1'b1, 4'd2, 3'b000, 1'b1,  2, 12'h224};
    vt[24] = '{3'b101, 1'b0, 1'b1, 4'd0, 3'b100, 1'b0, -1, 12'h224};
    vt[25] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  2, 12'h223};
    vt[26] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b001, 1'b0, -1, 12'h323};
    vt[27] = '{3'b001, 1'b0, 1'b0, 4'd0, 3'b000, 1'b1,  0, 12'h323};
    vt[28] = '{3'b000, 1'b0, 1'b1, 4'd1, 3'b000, 1'b0, -1, 12'h324};
    vt[29] = '{3'b000, 1'b0, 1'b1, 4'd1, 3'b000, 1'b0, -1, 12'h314};
    vt[30] = '{3'b000, 1'b0, 1'b1, 4'd1, 3'b000, 1'b0, -1, 12'h304};
    vt[31] = '{3'b000, 1'b0, 1'b1, 4'd3, 3'b000, 1'b0, -1, 12'h304};
    vt[32] = '{3'b000, 1'b0, 1'b0, 4'd0, 3'b000, 1'b0, -1, 12'h304};

    bus_if.arid_m[0] = 4'hA; bus_if.araddr_m[0] = 32'h0000_1234;
    bus_if.arlen_m[0] = 4'd0; bus_if.arsize_m[0] = 3'd1; bus_if.arburst_m[0] = 2'b00;
    bus_if.arid_m[1] = 4'h3; bus_if.araddr_m[1] = 32'h1000_0040;
    bus_if.arlen_m[1] = 4'd3; bus_if.arsize_m[1] = 3'd2; bus_if.arburst_m[1] = 2'b01;
    bus_if.arid_m[2] = 4'h5; bus_if.araddr_m[2] = 32'hDEAD_BEE0;
    bus_if.arlen_m[2] = 4'hF; bus_if.arsize_m[2] = 3'd3; bus_if.arburst_m[2] = 2'b10;

    // Reset state, with every master requesting
    rstn = 1'b1;
    drive(3'b111, 1'b0, 1'b0, 4'd0);
    #1 rstn = 1'b0;
    #11;
    chk("reset_arready", 64'(bus_if.arready_m), 64'h0);
    chk("reset_wpush",   64'(bus_if.wpush),     64'h0);
    chk("reset_wdata",   64'(bus_if.wdata),     64'h0);
    chk("reset_cnt",     64'(bus_if.outs_cnt),  64'h0);
    @(posedge clk); #1 rstn = 1'b1;

    // Fairness, backpressure, outstanding limit, same-cycle retire, saturating retire
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].vld, vt[i].full, vt[i].rd, vt[i].rdm);
      #3;
      chk($sformatf("v%0d_arready", i), 64'(bus_if.arready_m), 64'(vt[i].rdy));
      chk($sformatf("v%0d_wpush", i),   64'(bus_if.wpush),     64'(vt[i].push));
      chk($sformatf("v%0d_cnt", i),     64'(bus_if.outs_cnt),  64'(vt[i].cnt));
      if (vt[i].pm >= 0)
        chk($sformatf("v%0d_wdata", i), 64'(bus_if.wdata), 64'(wexp[vt[i].pm]));
      @(posedge clk); #1;
    end

    // Single request from M1
    drive(3'b010, 1'b0, 1'b0, 4'd0);
    #3 chk("single_arready", 64'(bus_if.arready_m), 64'h2);
    @(posedge clk); #1 drive(3'b000, 1'b0, 1'b0, 4'd0);
    #3;
    chk("single_wpush", 64'(bus_if.wpush), 64'h1);
    chk("single_wdata", 64'(bus_if.wdata), 64'(wexp[1]));
    @(posedge clk); #1;
    #3;
    chk("single_wpush_drop", 64'(bus_if.wpush),    64'h0);
    chk("single_cnt",        64'(bus_if.outs_cnt), 64'h314);

    // Reset pulsed while a word is pending
    @(posedge clk); #1 drive(3'b010, 1'b0, 1'b0, 4'd0);
    #3 chk("rst_pend_arready", 64'(bus_if.arready_m), 64'h2);
    @(posedge clk); #1 drive(3'b000, 1'b0, 1'b0, 4'd0);
    #1 chk("rst_pend_wpush", 64'(bus_if.wpush), 64'h1);
    acc_before = accepts;
    #1 rstn = 1'b0;
    #1;
    chk("rst_async_wpush", 64'(bus_if.wpush),    64'h0);
    chk("rst_async_cnt",   64'(bus_if.outs_cnt), 64'h0);
    drive(3'b111, 1'b0, 1'b0, 4'd0);
    #1 chk("rst_async_arready", 64'(bus_if.arready_m), 64'h0);
    repeat (2) @(posedge clk);
    #1 chk("rst_no_push", 64'(accepts), 64'(acc_before));
    rstn = 1'b1;
    #3 chk("rst_first_grant", 64'(bus_if.arready_m), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
